// File: rtl/hv_wdg_reg_scan_pkg.sv
// Widths, CRC-8 polynomial and scanner FSM encoding shared by the register-watchdog scan path.
package hv_wdg_reg_scan_pkg;

  localparam int REG_AW    = 7;
  localparam int REG_DW    = 8;
  localparam int REG_CRC_W = 8;

  localparam logic [REG_CRC_W-1:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {IDLE, REQ, CHK, INTV} wdg_scan_st_e;

  typedef struct packed {
    logic [REG_DW-1:0]    data;
    logic [REG_CRC_W-1:0] crc;
  } rd_rsp_t;

  // One MSB-first shift of a non-reflected CRC-8 register.
  function automatic logic [REG_CRC_W-1:0] crc8_step(input logic [REG_CRC_W-1:0] crc,
                                                     input logic                 din);
    logic fb;
    fb = crc[REG_CRC_W-1] ^ din;
    return {crc[REG_CRC_W-2:0], 1'b0} ^ (fb ? CRC8_POLY : '0);
  endfunction

endpackage

// File: rtl/hv_wdg_reg_scan_if.sv
// Watchdog-scan read port between the scanner (master) and the register access controller (slave).
interface hv_wdg_reg_scan_if;

  logic                                       o_wdg_scan_rac_rd_req;
  logic [hv_wdg_reg_scan_pkg::REG_AW-1:0]     o_wdg_scan_rac_addr;
  logic                                       i_rac_wdg_scan_ack;
  logic [hv_wdg_reg_scan_pkg::REG_DW-1:0]     i_rac_wdg_scan_data;
  logic [hv_wdg_reg_scan_pkg::REG_CRC_W-1:0]  i_rac_wdg_scan_crc;

  modport master (
    output o_wdg_scan_rac_rd_req,
    output o_wdg_scan_rac_addr,
    input  i_rac_wdg_scan_ack,
    input  i_rac_wdg_scan_data,
    input  i_rac_wdg_scan_crc
  );

  modport slave (
    input  o_wdg_scan_rac_rd_req,
    input  o_wdg_scan_rac_addr,
    output i_rac_wdg_scan_ack,
    output i_rac_wdg_scan_data,
    output i_rac_wdg_scan_crc
  );

endinterface

// File: rtl/hv_reg_crc_gen.sv
// Combinational CRC-8 (poly 0x07, init 0, no reflection, no final XOR) over REG_DW data bits, MSB first.
// Zero latency; no handshake.
module hv_reg_crc_gen
  import hv_wdg_reg_scan_pkg::*;
(
  input  logic [REG_DW-1:0]    data_i,
  output logic [REG_CRC_W-1:0] crc_o
);

  logic [REG_CRC_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = REG_DW - 1; i >= 0; i--) begin
      acc = crc8_step(acc, data_i[i]);
    end
    crc_o = acc;
  end

endmodule

// File: rtl/hv_wdg_reg_scan.sv
// Periodic read-only CRC scan of a register window via the rac wdg-scan port; flags CRC mismatch / ack timeout.
// One read outstanding; req held until ack or ACK_TO cycles; all outputs registered (pulses one cycle after CHK/timeout).
// Optional saturating error counter enabled by defining HV_WDG_SCAN_ERR_CNT_EN.
module hv_wdg_reg_scan
  import hv_wdg_reg_scan_pkg::*;
#(
  parameter logic [REG_AW-1:0] SCAN_START = 7'h00,
  parameter logic [REG_AW-1:0] SCAN_END   = 7'h03,
  parameter int unsigned       SCAN_INTV  = 16,
  parameter int unsigned       ACK_TO     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_scan_en,
  hv_wdg_reg_scan_if.master        rac,
  output logic                     o_scan_crc_err,
  output logic                     o_scan_to_err,
  output logic [REG_AW-1:0]        o_scan_err_addr,
  output logic                     o_scan_pass_done,
  output logic [7:0]               o_scan_err_cnt,
  input  logic                     i_scan_err_cnt_clr
);

  localparam int INTV_W = $clog2(SCAN_INTV + 1);
  localparam int TO_W   = $clog2(ACK_TO + 1);
  localparam logic [INTV_W-1:0] INTV_LAST = INTV_W'(SCAN_INTV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TO - 1);

  wdg_scan_st_e         state_q, state_d;
  logic [REG_AW-1:0]    addr_q, addr_d;
  logic                 req_q, req_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [INTV_W-1:0]    intv_cnt_q, intv_cnt_d;
  rd_rsp_t              rsp_q, rsp_d;
  logic                 to_hit_q, to_hit_d;
  logic                 crc_err_q, crc_err_d;
  logic                 to_err_q, to_err_d;
  logic [REG_AW-1:0]    err_addr_q, err_addr_d;
  logic                 pass_done_q, pass_done_d;
  logic [REG_CRC_W-1:0] crc_calc;

  hv_reg_crc_gen u_crc (
    .data_i (rsp_q.data),
    .crc_o  (crc_calc)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    req_d       = req_q;
    to_cnt_d    = to_cnt_q;
    intv_cnt_d  = intv_cnt_q;
    rsp_d       = rsp_q;
    to_hit_d    = to_hit_q;
    crc_err_d   = 1'b0;
    to_err_d    = 1'b0;
    err_addr_d  = err_addr_q;
    pass_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_scan_en) begin
          addr_d   = SCAN_START;
          to_cnt_d = '0;
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        // An ack in the final timeout cycle still counts as a good read.
        if (rac.i_rac_wdg_scan_ack) begin
          rsp_d.data = rac.i_rac_wdg_scan_data;
          rsp_d.crc  = rac.i_rac_wdg_scan_crc;
          to_hit_d   = 1'b0;
          req_d      = 1'b0;
          state_d    = CHK;
        end else if (to_cnt_q == TO_LAST) begin
          to_err_d   = 1'b1;
          err_addr_d = addr_q;
          to_hit_d   = 1'b1;
          req_d      = 1'b0;
          state_d    = CHK;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHK: begin
        if (!to_hit_q && (crc_calc != rsp_q.crc)) begin
          crc_err_d  = 1'b1;
          err_addr_d = addr_q;
        end
        if (addr_q == SCAN_END) begin
          pass_done_d = 1'b1;
          intv_cnt_d  = '0;
          state_d     = INTV;
        end else begin
          addr_d   = addr_q + 1'b1;
          to_cnt_d = '0;
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end
      INTV: begin
        if (intv_cnt_q == INTV_LAST) begin
          addr_d   = SCAN_START;
          to_cnt_d = '0;
          req_d    = 1'b1;
          state_d  = REQ;
        end else begin
          intv_cnt_d = intv_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable aborts silently from any state: no pulses, error address kept.
    if (!i_scan_en) begin
      state_d     = IDLE;
      req_d       = 1'b0;
      crc_err_d   = 1'b0;
      to_err_d    = 1'b0;
      pass_done_d = 1'b0;
      err_addr_d  = err_addr_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      addr_q      <= SCAN_START;
      req_q       <= 1'b0;
      to_cnt_q    <= '0;
      intv_cnt_q  <= '0;
      rsp_q       <= '0;
      to_hit_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
      err_addr_q  <= '0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      to_cnt_q    <= to_cnt_d;
      intv_cnt_q  <= intv_cnt_d;
      rsp_q       <= rsp_d;
      to_hit_q    <= to_hit_d;
      crc_err_q   <= crc_err_d;
      to_err_q    <= to_err_d;
      err_addr_q  <= err_addr_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign rac.o_wdg_scan_rac_rd_req = req_q;
  assign rac.o_wdg_scan_rac_addr   = addr_q;
  assign o_scan_crc_err            = crc_err_q;
  assign o_scan_to_err             = to_err_q;
  assign o_scan_err_addr           = err_addr_q;
  assign o_scan_pass_done          = pass_done_q;

`ifdef HV_WDG_SCAN_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts from the same next-state pulses so the count and the pulse appear together.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (i_scan_err_cnt_clr) begin
      err_cnt_d = '0;
    end else if ((crc_err_d || to_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_scan_err_cnt = err_cnt_q;
`else
  logic unused_err_cnt_clr;
  assign unused_err_cnt_clr = i_scan_err_cnt_clr;
  assign o_scan_err_cnt     = '0;
`endif

endmodule

// File: tb/tb_hv_wdg_reg_scan.sv
// Bench for hv_wdg_reg_scan: table of rac read responses with expected pulses, plus scan-disable, reset and counter sequences.
module tb_hv_wdg_reg_scan;
  import hv_wdg_reg_scan_pkg::*;

  localparam int SCAN_INTV = 16;
  localparam int ACK_TO    = 8;
  localparam int NOACK     = 255;
  localparam int NVEC      = 13;
`ifdef HV_WDG_SCAN_ERR_CNT_EN
  localparam int EXP_TBL_ERRS = 3;
`else
  localparam int EXP_TBL_ERRS = 0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_scan_en;
  logic              i_scan_err_cnt_clr;
  logic              o_scan_crc_err;
  logic              o_scan_to_err;
  logic [REG_AW-1:0] o_scan_err_addr;
  logic              o_scan_pass_done;
  logic [7:0]        o_scan_err_cnt;

  hv_wdg_reg_scan_if rac ();

  hv_wdg_reg_scan dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_scan_en          (i_scan_en),
    .rac                (rac),
    .o_scan_crc_err     (o_scan_crc_err),
    .o_scan_to_err      (o_scan_to_err),
    .o_scan_err_addr    (o_scan_err_addr),
    .o_scan_pass_done   (o_scan_pass_done),
    .o_scan_err_cnt     (o_scan_err_cnt),
    .i_scan_err_cnt_clr (i_scan_err_cnt_clr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [REG_AW-1:0] addr;
    int                dly;
    logic [7:0]        data;
    logic [7:0]        crc;
    logic              exp_crc;
    logic              exp_to;
    logic              exp_pass;
  } vec_t;

  typedef struct packed {
    logic              crc;
    logic              to;
    logic              pass;
    logic [REG_AW-1:0] addr;
  } evt_t;

  vec_t vt [NVEC];
  evt_t exp_q [$];
  evt_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_pass_cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Error/pass pulses are matched in order against what the driver queued.
  always @(negedge i_clk) begin
    if (!i_rst && (o_scan_crc_err || o_scan_to_err || o_scan_pass_done)) begin
      if (o_scan_pass_done) last_pass_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, o_scan_crc_err, o_scan_to_err, o_scan_pass_done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {29'd0, o_scan_crc_err, o_scan_to_err, o_scan_pass_done},
              {29'd0, mon_e.crc, mon_e.to, mon_e.pass});
        if (mon_e.crc || mon_e.to) check("err_addr", 32'(o_scan_err_addr), 32'(mon_e.addr));
      end
    end
  end

  task automatic wait_req();
    int w = 0;
    while (rac.o_wdg_scan_rac_rd_req !== 1'b1 && w < 64) begin
      @(negedge i_clk);
      w++;
    end
  endtask

  task automatic do_read(input vec_t v, input logic clr_at_chk);
    int low = 0;
    wait_req();
    check("req_rise", 32'(rac.o_wdg_scan_rac_rd_req), 32'd1);
    check("rd_addr", 32'(rac.o_wdg_scan_rac_addr), 32'(v.addr));
    if (v.exp_crc || v.exp_to || v.exp_pass) exp_q.push_back({v.exp_crc, v.exp_to, v.exp_pass, v.addr});
    if (v.dly == NOACK) begin
      repeat (ACK_TO - 1) begin
        @(negedge i_clk);
        if (rac.o_wdg_scan_rac_rd_req !== 1'b1) low++;
      end
      @(negedge i_clk);
      check("to_req_drop", 32'(rac.o_wdg_scan_rac_rd_req), 32'd0);
      rac.i_rac_wdg_scan_ack  = 1'b1;
      rac.i_rac_wdg_scan_data = v.data;
      rac.i_rac_wdg_scan_crc  = v.crc;
      @(negedge i_clk);
      rac.i_rac_wdg_scan_ack  = 1'b0;
    end else begin
      repeat (v.dly) begin
        @(negedge i_clk);
        if (rac.o_wdg_scan_rac_rd_req !== 1'b1) low++;
      end
      rac.i_rac_wdg_scan_ack  = 1'b1;
      rac.i_rac_wdg_scan_data = v.data;
      rac.i_rac_wdg_scan_crc  = v.crc;
      @(negedge i_clk);
      rac.i_rac_wdg_scan_ack  = 1'b0;
      rac.i_rac_wdg_scan_data = 8'($urandom);
      rac.i_rac_wdg_scan_crc  = 8'($urandom);
      i_scan_err_cnt_clr      = clr_at_chk;
      check("ack_req_drop", 32'(rac.o_wdg_scan_rac_rd_req), 32'd0);
    end
    check("req_hold", 32'(low), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t hv;
    // addr, ack delay, data, crc, expected crc_err / to_err / pass_done
    vt[0]  = '{7'h00, 3,     8'h01, 8'h07, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{7'h01, 3,     8'h02, 8'h0E, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{7'h02, 3,     8'h03, 8'h09, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{7'h03, 3,     8'h80, 8'h89, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{7'h00, 3,     8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{7'h01, 4,     8'hA5, 8'h72, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{7'h02, 3,     8'hA5, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{7'h03, 5,     8'h01, 8'h07, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{7'h00, 3,     8'h04, 8'h1C, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{7'h01, NOACK, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0};
    vt[10] = '{7'h02, 6,     8'h02, 8'h0E, 1'b0, 1'b0, 1'b0};
    vt[11] = '{7'h03, 3,     8'h80, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[12] = '{7'h00, 7,     8'h01, 8'h07, 1'b0, 1'b0, 1'b0};

    i_rst = 1'b1;
    i_scan_en = 1'b1;
    i_scan_err_cnt_clr = 1'b0;
    rac.i_rac_wdg_scan_ack  = 1'b0;
    rac.i_rac_wdg_scan_data = '0;
    rac.i_rac_wdg_scan_crc  = '0;
    repeat (3) @(negedge i_clk);
    check("rst_req", 32'(rac.o_wdg_scan_rac_rd_req), 32'd0);
    check("rst_addr", 32'(rac.o_wdg_scan_rac_addr), 32'd0);
    check("rst_pulses", {29'd0, o_scan_crc_err, o_scan_to_err, o_scan_pass_done}, 32'd0);
    check("rst_err_addr", 32'(o_scan_err_addr), 32'd0);
    check("rst_err_cnt", 32'(o_scan_err_cnt), 32'd0);
    i_rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      wait_req();
      if (i > 0 && vt[i].addr == 7'h00) check("intv_gap", 32'(cyc - last_pass_cyc), 32'(SCAN_INTV));
      do_read(vt[i], 1'b0);
    end
    check("cnt_after_table", 32'(o_scan_err_cnt), 32'(EXP_TBL_ERRS));

    // Disable mid-REQ, then an ack while idle must be ignored.
    wait_req();
    check("drop_addr", 32'(rac.o_wdg_scan_rac_addr), 32'd1);
    i_scan_en = 1'b0;
    @(negedge i_clk);
    check("drop_req", 32'(rac.o_wdg_scan_rac_rd_req), 32'd0);
    rac.i_rac_wdg_scan_ack  = 1'b1;
    rac.i_rac_wdg_scan_data = 8'h01;
    rac.i_rac_wdg_scan_crc  = 8'h00;
    @(negedge i_clk);
    rac.i_rac_wdg_scan_ack  = 1'b0;
    repeat (4) @(negedge i_clk);
    check("idle_hold", 32'(rac.o_wdg_scan_rac_rd_req), 32'd0);
    i_scan_en = 1'b1;
    @(negedge i_clk);
    check("reen_req", 32'(rac.o_wdg_scan_rac_rd_req), 32'd1);
    check("reen_addr", 32'(rac.o_wdg_scan_rac_addr), 32'd0);
    hv = '{7'h00, 3, 8'h01, 8'h07, 1'b0, 1'b0, 1'b0};
    do_read(hv, 1'b0);

    // Reset with a bad-CRC ack in flight.
    wait_req();
    rac.i_rac_wdg_scan_ack  = 1'b1;
    rac.i_rac_wdg_scan_data = 8'h01;
    rac.i_rac_wdg_scan_crc  = 8'h00;
    i_rst = 1'b1;
    @(negedge i_clk);
    rac.i_rac_wdg_scan_ack = 1'b0;
    check("mid_rst_out", {22'd0, rac.o_wdg_scan_rac_rd_req, rac.o_wdg_scan_rac_addr, o_scan_err_addr}, 32'd0);
    check("mid_rst_cnt", 32'(o_scan_err_cnt), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    hv = '{7'h00, 3, 8'h02, 8'h0E, 1'b0, 1'b0, 1'b0};
    do_read(hv, 1'b0);

`ifdef HV_WDG_SCAN_ERR_CNT_EN
    for (int k = 0; k < 300; k++) begin
      hv = '{REG_AW'((k + 1) % 4), 3, 8'h01, 8'h00, 1'b1, 1'b0, ((k + 1) % 4) == 3};
      do_read(hv, 1'b0);
      if (k == 9) begin
        @(negedge i_clk);
        check("cnt_ten", 32'(o_scan_err_cnt), 32'd10);
      end
    end
    @(negedge i_clk);
    check("cnt_sat", 32'(o_scan_err_cnt), 32'hFF);
    hv = '{7'h01, 3, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    do_read(hv, 1'b1);
    @(negedge i_clk);
    i_scan_err_cnt_clr = 1'b0;
    check("clr_wins", 32'(o_scan_err_cnt), 32'd0);
    hv = '{7'h02, 3, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0};
    do_read(hv, 1'b0);
    @(negedge i_clk);
    check("cnt_after_clr", 32'(o_scan_err_cnt), 32'd1);
`else
    hv = '{7'h01, 3, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    do_read(hv, 1'b1);
    @(negedge i_clk);
    i_scan_err_cnt_clr = 1'b0;
    check("cnt_tied", 32'(o_scan_err_cnt), 32'd0);
`endif

    repeat (3) @(negedge i_clk);
    check("evt_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
